// File: rtl/data_mem_responder_pkg.sv
// Shared bus definitions for the data memory responder: widths, the
// response record carried through the latency pipeline, and the
// SECDED(39,32) check-bit encoder used for both write and read integrity.
package data_mem_responder_pkg;

  localparam int unsigned BUS_DATA_W    = 32;
  localparam int unsigned BUS_ADDR_W    = 32;
  localparam int unsigned SECDED_INTG_W = 7;

  // One response slot: valid flag, error flag and read data.
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [BUS_DATA_W-1:0] rdata;
  } rsp_t;

  // Check bits of a Hsiao SECDED(39,32) code; each bit is the parity of
  // the data bits selected by its column mask.
  function automatic logic [SECDED_INTG_W-1:0] secded_39_32_enc_fn(
    input logic [BUS_DATA_W-1:0] data
  );
    logic [SECDED_INTG_W-1:0] intg;
    intg[0] = ^(data & 32'h2606_BD25);
    intg[1] = ^(data & 32'hDEBA_8050);
    intg[2] = ^(data & 32'h413D_89AA);
    intg[3] = ^(data & 32'h3123_4ED1);
    intg[4] = ^(data & 32'hC2C1_323B);
    intg[5] = ^(data & 32'h2DCC_624C);
    intg[6] = ^(data & 32'h9850_5586);
    return intg;
  endfunction

endpackage

// File: rtl/data_mem_responder_secded.sv
// Purely combinational SECDED(39,32) check-bit generator. Shared with the
// instruction-memory responder, so it carries no state and no clock.
module secded_39_32_enc
  import data_mem_responder_pkg::*;
(
  input  logic [BUS_DATA_W-1:0]    data_i,
  output logic [SECDED_INTG_W-1:0] intg_o
);

  assign intg_o = secded_39_32_enc_fn(data_i);

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store req/gnt/rvalid bus. Models a
// word-addressed, byte-enabled SRAM with programmable grant wait states and
// a fixed-latency response pipeline. Out-of-range addresses and writes whose
// integrity bits do not match the data are answered with an error response
// and never touch memory.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned           MEM_WORDS   = 4096,
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned           GNT_WAIT    = 0,
  parameter int unsigned           RVALID_LAT  = 1,
  parameter int unsigned           CHECK_WINTG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_req_i,
  output logic                     data_gnt_o,
  input  logic [BUS_ADDR_W-1:0]    data_addr_i,
  input  logic                     data_we_i,
  input  logic [3:0]               data_be_i,
  input  logic [BUS_DATA_W-1:0]    data_wdata_i,
  input  logic [SECDED_INTG_W-1:0] data_wdata_intg_i,
  output logic                     data_rvalid_o,
  output logic [BUS_DATA_W-1:0]    data_rdata_o,
  output logic [SECDED_INTG_W-1:0] data_rdata_intg_o,
  output logic                     data_err_o
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0]      GNT_WAIT_C = CNT_W'(GNT_WAIT);
  localparam logic [BUS_ADDR_W-1:0] MEM_BYTES  = BUS_ADDR_W'(4 * MEM_WORDS);
  localparam logic                  WINTG_EN   = (CHECK_WINTG != 0);

  logic [CNT_W-1:0]         wait_cnt_r;
  logic                     gnt_s;
  logic [BUS_ADDR_W-1:0]    addr_off_s;
  logic                     in_range_s;
  logic [SECDED_INTG_W-1:0] wintg_calc_s;
  logic                     wintg_err_s;
  logic                     req_err_s;
  logic [IDX_W-1:0]         mem_idx_s;
  logic                     mem_we_s;
  logic [BUS_DATA_W-1:0]    rd_word_s;
  rsp_t                     rsp_in_s;
  rsp_t                     pipe_r [RVALID_LAT];
  logic [BUS_DATA_W-1:0]    mem_r  [MEM_WORDS];

  // Grant once req has been held for GNT_WAIT cycles; same cycle when zero.
  assign gnt_s      = data_req_i && (wait_cnt_r == GNT_WAIT_C);
  assign data_gnt_o = gnt_s;

  // Wait-state counter: counts ungranted req cycles, clears on grant or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else if (!data_req_i || gnt_s) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end

  // Offset-based range check; wrap-around of addresses below the base lands
  // far above MEM_BYTES, but the explicit lower bound keeps intent obvious.
  assign addr_off_s = data_addr_i - BASE_ADDR;
  assign in_range_s = (data_addr_i >= BASE_ADDR) && (addr_off_s < MEM_BYTES);
  assign mem_idx_s  = addr_off_s[IDX_W+1:2];

  secded_39_32_enc u_wdata_enc (
    .data_i (data_wdata_i),
    .intg_o (wintg_calc_s)
  );

  assign wintg_err_s = WINTG_EN && data_we_i && (wintg_calc_s != data_wdata_intg_i);
  assign req_err_s   = !in_range_s || wintg_err_s;
  assign mem_we_s    = gnt_s && data_we_i && !req_err_s;
  assign rd_word_s   = mem_r[mem_idx_s];

  // Build the response for the request accepted this cycle (if any).
  always_comb begin
    rsp_in_s = '0;
    if (gnt_s) begin
      rsp_in_s.valid = 1'b1;
      rsp_in_s.err   = req_err_s;
      if (!req_err_s && !data_we_i) begin
        rsp_in_s.rdata = rd_word_s;
      end else begin
        rsp_in_s.rdata = '0;
      end
    end else begin
      rsp_in_s = '0;
    end
  end

  // Byte-enabled write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_r[mem_idx_s][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Fixed-latency response shift register; reset drops in-flight responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RVALID_LAT; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= rsp_in_s;
      for (int i = 1; i < RVALID_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign data_rvalid_o = pipe_r[RVALID_LAT-1].valid;
  assign data_err_o    = pipe_r[RVALID_LAT-1].err;
  assign data_rdata_o  = pipe_r[RVALID_LAT-1].rdata;

  // Check bits follow the registered read data, so they are valid every cycle.
  secded_39_32_enc u_rdata_enc (
    .data_i (data_rdata_o),
    .intg_o (data_rdata_intg_o)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Instance 0 uses same-cycle grant
// and single-cycle latency; instance 1 uses two wait states and a three-stage
// response pipeline.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req0, we0, gnt0, rvalid0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;
  logic [6:0]  wintg0, rintg0;

  logic        req1, we1, gnt1, rvalid1, err1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0]  be1;
  logic [6:0]  wintg1, rintg1;

  int n_vec  = 0;
  int n_fail = 0;

  data_mem_responder #(
    .MEM_WORDS(4096), .BASE_ADDR(32'h0001_0000), .GNT_WAIT(0),
    .RVALID_LAT(1), .CHECK_WINTG(1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req0), .data_gnt_o(gnt0),
    .data_addr_i(addr0), .data_we_i(we0), .data_be_i(be0),
    .data_wdata_i(wdata0), .data_wdata_intg_i(wintg0),
    .data_rvalid_o(rvalid0), .data_rdata_o(rdata0),
    .data_rdata_intg_o(rintg0), .data_err_o(err0)
  );

  data_mem_responder #(
    .MEM_WORDS(4096), .BASE_ADDR(32'h0001_0000), .GNT_WAIT(2),
    .RVALID_LAT(3), .CHECK_WINTG(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_req_i(req1), .data_gnt_o(gnt1),
    .data_addr_i(addr1), .data_we_i(we1), .data_be_i(be1),
    .data_wdata_i(wdata1), .data_wdata_intg_i(wintg1),
    .data_rvalid_o(rvalid1), .data_rdata_o(rdata1),
    .data_rdata_intg_o(rintg1), .data_err_o(err1)
  );

  // Reference SECDED(39,32) check bits (Hsiao column masks).
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] p;
    p[0] = ^(d & 32'h2606_BD25);
    p[1] = ^(d & 32'hDEBA_8050);
    p[2] = ^(d & 32'h413D_89AA);
    p[3] = ^(d & 32'h3123_4ED1);
    p[4] = ^(d & 32'hC2C1_323B);
    p[5] = ^(d & 32'h2DCC_624C);
    p[6] = ^(d & 32'h9850_5586);
    return p;
  endfunction

  // One transaction on instance 0, entered and left on a falling edge.
  task automatic acc0(input string name, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input logic [6:0] wi,
                      input logic exp_err, input logic [31:0] exp_rd);
    req0 = 1'b1; we0 = we; addr0 = addr; be0 = be; wdata0 = wd; wintg0 = wi;
    #1;
    n_vec++;
    if (gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s gnt: got %b want 1", name, gnt0);
    end
    @(negedge clk);
    req0 = 1'b0;
    n_vec++;
    if (rvalid0 !== 1'b1 || err0 !== exp_err || rdata0 !== exp_rd || rintg0 !== enc(exp_rd)) begin
      n_fail++;
      $display("FAIL %s rsp: got v=%b e=%b d=%h i=%h want v=1 e=%b d=%h i=%h",
               name, rvalid0, err0, rdata0, rintg0, exp_err, exp_rd, enc(exp_rd));
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; be0 = 4'h0; wdata0 = 32'h0; wintg0 = 7'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; be1 = 4'h0; wdata1 = 32'h0; wintg1 = 7'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (rvalid0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'h0 || rintg0 !== enc(32'h0) ||
          rvalid1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== 32'h0 || rintg1 !== enc(32'h0)) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got v=%b/%b e=%b/%b d=%h/%h i=%h/%h want all 0, i=%h",
                 c, rvalid0, rvalid1, err0, err1, rdata0, rdata1, rintg0, rintg1, enc(32'h0));
      end
    end
  endtask

  task automatic test_write_read;
    acc0("wr_deadbeef", 1'b1, 32'h0001_0010, 4'hF, 32'hDEAD_BEEF, enc(32'hDEAD_BEEF), 1'b0, 32'h0);
    acc0("rd_deadbeef", 1'b0, 32'h0001_0010, 4'hF, 32'h0, 7'h0, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    n_vec++;
    if (rvalid0 !== 1'b0 || rdata0 !== 32'h0 || rintg0 !== enc(32'h0)) begin
      n_fail++;
      $display("FAIL idle_after_rd: got v=%b d=%h i=%h want v=0 d=0 i=%h",
               rvalid0, rdata0, rintg0, enc(32'h0));
    end
  endtask

  task automatic test_byte_enable;
    acc0("be_preload", 1'b1, 32'h0001_0020, 4'hF, 32'h1122_3344, enc(32'h1122_3344), 1'b0, 32'h0);
    acc0("be_wr_0101", 1'b1, 32'h0001_0020, 4'b0101, 32'hAABB_CCDD, enc(32'hAABB_CCDD), 1'b0, 32'h0);
    acc0("be_rd_merged", 1'b0, 32'h0001_0020, 4'h0, 32'h0, 7'h0, 1'b0, 32'h11BB_33DD);
    acc0("be_wr_none", 1'b1, 32'h0001_0020, 4'h0, 32'h0000_0000, enc(32'h0), 1'b0, 32'h0);
    acc0("be_rd_after_none", 1'b0, 32'h0001_0020, 4'hF, 32'h0, 7'h0, 1'b0, 32'h11BB_33DD);
  endtask

  task automatic test_out_of_range;
    acc0("oor_preload_idx0", 1'b1, 32'h0001_0000, 4'hF, 32'h5A5A_1234, enc(32'h5A5A_1234), 1'b0, 32'h0);
    acc0("oor_rd_below", 1'b0, 32'h0000_FFFC, 4'hF, 32'h0, 7'h0, 1'b1, 32'h0);
    acc0("oor_wr_above", 1'b1, 32'h0001_4000, 4'hF, 32'hFFFF_FFFF, enc(32'hFFFF_FFFF), 1'b1, 32'h0);
    acc0("oor_idx0_intact", 1'b0, 32'h0001_0000, 4'hF, 32'h0, 7'h0, 1'b0, 32'h5A5A_1234);
    acc0("last_word_wr", 1'b1, 32'h0001_3FFC, 4'hF, 32'h7E57_0FF5, enc(32'h7E57_0FF5), 1'b0, 32'h0);
    acc0("last_word_rd", 1'b0, 32'h0001_3FFF, 4'hF, 32'h0, 7'h0, 1'b0, 32'h7E57_0FF5);
  endtask

  task automatic test_wintg;
    acc0("wintg_good", 1'b1, 32'h0001_0030, 4'hF, 32'h0BAD_F00D, enc(32'h0BAD_F00D), 1'b0, 32'h0);
    acc0("wintg_bad", 1'b1, 32'h0001_0030, 4'hF, 32'hFFFF_0000, enc(32'hFFFF_0000) ^ 7'h01, 1'b1, 32'h0);
    acc0("wintg_intact", 1'b0, 32'h0001_0030, 4'hF, 32'h0, 7'h0, 1'b0, 32'h0BAD_F00D);
  endtask

  // Four writes then four reads on instance 1 with req held continuously.
  task automatic test_wait_lat3;
    logic [31:0] addrs [4] = '{32'h0001_0100, 32'h0001_0104, 32'h0001_0108, 32'h0001_010C};
    logic [31:0] datas [4] = '{32'hCAFE_0001, 32'h1234_5678, 32'h0F0F_0F0F, 32'h8000_0001};
    int          due [$];
    logic [31:0] exp_q [$];
    int          op   = 0;
    int          held = 0;
    logic        exp_g;
    logic        exp_v;
    req1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = addrs[0]; wdata1 = datas[0]; wintg1 = enc(datas[0]);
    for (int c = 0; c < 40; c++) begin
      #1;
      held  = req1 ? held + 1 : 0;
      exp_g = req1 && (held == 3);
      n_vec++;
      if (gnt1 !== exp_g) begin
        n_fail++;
        $display("FAIL lat3_gnt cyc%0d: got %b want %b", c, gnt1, exp_g);
      end
      exp_v = (due.size() > 0) && (due[0] == c);
      n_vec++;
      if (rvalid1 !== exp_v) begin
        n_fail++;
        $display("FAIL lat3_rvalid cyc%0d: got %b want %b", c, rvalid1, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (err1 !== 1'b0 || rdata1 !== exp_q[0] || rintg1 !== enc(exp_q[0])) begin
          n_fail++;
          $display("FAIL lat3_rdata cyc%0d: got e=%b d=%h i=%h want e=0 d=%h i=%h",
                   c, err1, rdata1, rintg1, exp_q[0], enc(exp_q[0]));
        end
        void'(due.pop_front());
        void'(exp_q.pop_front());
      end
      if (exp_g) begin
        due.push_back(c + 3);
        exp_q.push_back((op < 4) ? 32'h0 : datas[op % 4]);
        held = 0;
      end
      @(posedge clk);
      #1;
      if (exp_g) begin
        op++;
        if (op < 8) begin
          we1 = (op < 4); addr1 = addrs[op % 4]; wdata1 = datas[op % 4]; wintg1 = enc(datas[op % 4]);
        end else begin
          req1 = 1'b0;
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (due.size() != 0) begin
      n_fail++;
      $display("FAIL lat3_all_rsp: got %0d responses missing want 0", due.size());
    end
  endtask

  // Reset with a read in flight on instance 1: its response must never show.
  task automatic test_reset_midflight;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0001_0104;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (gnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_gnt: got %b want 1", gnt1);
    end
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (rvalid1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_in_reset: got rvalid %b want 0", rvalid1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (rvalid1 !== 1'b0 || rdata1 !== 32'h0) begin
        n_fail++;
        $display("FAIL rst_mid_dropped cyc%0d: got v=%b d=%h want v=0 d=0", c, rvalid1, rdata1);
      end
    end
    acc0("mem_kept_after_rst", 1'b0, 32'h0001_0010, 4'hF, 32'h0, 7'h0, 1'b0, 32'hDEAD_BEEF);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_out_of_range();
    test_wintg();
    test_wait_lat3();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
